hm_10_link_supervisor: RTL and testbench

HM_10_LINK_SUPERVISOR -- requirements
Module: hm_10_link_supervisor

---
 rtl/hm_10_link_supervisor.sv | 83 ++++++++
 tb/tb_hm_10_link_supervisor.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/hm_10_link_supervisor.sv
// hm_10_link_supervisor: gates BLE transmit on a stable link, counts link drops and drives a status LED.
module hm_10_link_supervisor #(
  parameter logic [31:0] HOLDOFF_CYCLES = 32'd500000,
  parameter logic [31:0] LOST_TIMEOUT   = 32'd2000000,
  parameter logic [31:0] BLINK_HALF     = 32'd250000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       connection_flag,
  input  logic       connection_warning_flag,
  input  logic       tx_request,
  output logic       tx_grant,
  output logic       link_up,
  output logic       flush_pulse,
  output logic       status_led,
  output logic [7:0] drop_count,
  output logic [1:0] state
);
  typedef enum logic [1:0] {
    DISCONNECTED = 2'b00,
    SETTLING     = 2'b01,
    LINKED       = 2'b10,
    WARNING      = 2'b11
  } state_t;
  state_t      cur, nxt;
  logic [31:0] timer, timer_d, blink;
  logic        drop;
  assign state    = cur;
  assign tx_grant = tx_request && (cur == LINKED);
  // timer_d defaults to 0, which also clears the timer on every transition
  always_comb begin
    nxt     = cur;
    drop    = 1'b0;
    timer_d = 32'd0;
    case (cur)
      DISCONNECTED: nxt = (connection_flag && !connection_warning_flag) ? SETTLING : DISCONNECTED;
      SETTLING: begin
        if (!connection_flag) nxt = DISCONNECTED;
        else if (connection_warning_flag) timer_d = 32'd0;
        else if (timer == HOLDOFF_CYCLES - 32'd1) nxt = LINKED;
        else timer_d = timer + 32'd1;
      end
      LINKED: begin
        if (!connection_flag) begin
          nxt  = DISCONNECTED;
          drop = 1'b1;
        end else if (connection_warning_flag) nxt = WARNING;
      end
      WARNING: begin
        if (!connection_flag || timer == LOST_TIMEOUT - 32'd1) begin
          nxt  = DISCONNECTED;
          drop = 1'b1;
        end else if (!connection_warning_flag) nxt = LINKED;
        else timer_d = timer + 32'd1;
      end
      default: nxt = DISCONNECTED;
    endcase
  end
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cur         <= DISCONNECTED;
      timer       <= 32'd0;
      blink       <= 32'd0;
      link_up     <= 1'b0;
      flush_pulse <= 1'b0;
      status_led  <= 1'b0;
      drop_count  <= 8'd0;
    end else begin
      cur         <= nxt;
      timer       <= timer_d;
      link_up     <= (nxt == LINKED) || (nxt == WARNING);
      flush_pulse <= drop;
      drop_count  <= (drop && drop_count != 8'hFF) ? drop_count + 8'd1 : drop_count;
      if (nxt != cur) begin
        blink      <= 32'd0;
        status_led <= (nxt != DISCONNECTED);
      end else if (cur == SETTLING || cur == WARNING) begin
        blink <= (blink == BLINK_HALF - 32'd1) ? 32'd0 : blink + 32'd1;
        if (blink == BLINK_HALF - 32'd1) status_led <= ~status_led;
      end
    end
  end
endmodule

// File: tb/tb_hm_10_link_supervisor.sv
// tb_hm_10_link_supervisor: directed vectors with hand-computed expectations for the link supervisor.
module tb_hm_10_link_supervisor;
  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       connection_flag = 1'b0;
  logic       connection_warning_flag = 1'b0;
  logic       tx_request = 1'b0;
  logic       tx_grant, link_up, flush_pulse, status_led;
  logic [7:0] drop_count;
  logic [1:0] state;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         exp_drop = 0;

  hm_10_link_supervisor #(
    .HOLDOFF_CYCLES(32'd4),
    .LOST_TIMEOUT  (32'd6),
    .BLINK_HALF    (32'd2)
  ) dut (
    .clock                  (clock),
    .resetn                 (resetn),
    .connection_flag        (connection_flag),
    .connection_warning_flag(connection_warning_flag),
    .tx_request             (tx_request),
    .tx_grant               (tx_grant),
    .link_up                (link_up),
    .flush_pulse            (flush_pulse),
    .status_led             (status_led),
    .drop_count             (drop_count),
    .state                  (state)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic go_linked();
    connection_flag = 1'b1;
    connection_warning_flag = 1'b0;
    repeat (5) tick();
  endtask

  initial begin
    tx_request = 1'b1;
    #12;
    check("rst_state", state, 0);
    check("rst_link_up", link_up, 0);
    check("rst_flush", flush_pulse, 0);
    check("rst_led", status_led, 0);
    check("rst_drops", drop_count, 0);
    check("rst_grant", tx_grant, 0);
    tick();
    resetn = 1'b1;
    tx_request = 1'b0;
    tick();
    check("idle_state", state, 0);
    // bring-up: SETTLING after one edge, LINKED four edges later
    connection_flag = 1'b1;
    tick();
    check("settle_state", state, 1);
    check("settle_led0", status_led, 1);
    check("settle_link_up", link_up, 0);
    tick();
    check("settle_led1", status_led, 1);
    tick();
    check("settle_led2", status_led, 0);
    tick();
    check("settle_hold", state, 1);
    tick();
    check("linked_state", state, 2);
    check("linked_link_up", link_up, 1);
    check("linked_led", status_led, 1);
    tx_request = 1'b1;
    #1;
    check("linked_grant", tx_grant, 1);
    // drop from LINKED
    connection_flag = 1'b0;
    tick();
    check("drop_state", state, 0);
    check("drop_flush", flush_pulse, 1);
    check("drop_count1", drop_count, 1);
    check("drop_grant", tx_grant, 0);
    check("drop_link_up", link_up, 0);
    check("drop_led", status_led, 0);
    tick();
    check("drop_flush_end", flush_pulse, 0);
    exp_drop = 1;
    // short warning returns to LINKED
    go_linked();
    check("relink", state, 2);
    connection_warning_flag = 1'b1;
    tick();
    check("warn_state", state, 3);
    check("warn_led0", status_led, 1);
    check("warn_link_up", link_up, 1);
    check("warn_grant", tx_grant, 0);
    tick();
    check("warn_led1", status_led, 1);
    tick();
    check("warn_led2", status_led, 0);
    connection_warning_flag = 1'b0;
    tick();
    check("warn_clear_state", state, 2);
    check("warn_clear_drops", drop_count, exp_drop);
    check("warn_clear_flush", flush_pulse, 0);
    // warning timeout
    connection_warning_flag = 1'b1;
    repeat (6) tick();
    check("timeout_pre", state, 3);
    check("timeout_pre_flush", flush_pulse, 0);
    tick();
    exp_drop++;
    check("timeout_state", state, 0);
    check("timeout_flush", flush_pulse, 1);
    check("timeout_drops", drop_count, exp_drop);
    tick();
    check("timeout_flush_end", flush_pulse, 0);
    // simultaneous loss and timeout: one drop
    go_linked();
    connection_warning_flag = 1'b1;
    repeat (6) tick();
    connection_flag = 1'b0;
    tick();
    exp_drop++;
    check("simul_state", state, 0);
    check("simul_flush", flush_pulse, 1);
    check("simul_drops", drop_count, exp_drop);
    tick();
    check("simul_flush_end", flush_pulse, 0);
    check("simul_drops_hold", drop_count, exp_drop);
    // loss during SETTLING is not a drop
    connection_flag = 1'b1;
    connection_warning_flag = 1'b0;
    repeat (3) tick();
    check("settle_loss_pre", state, 1);
    connection_flag = 1'b0;
    tick();
    check("settle_loss_state", state, 0);
    check("settle_loss_flush", flush_pulse, 0);
    check("settle_loss_drops", drop_count, exp_drop);
    // warning pulse restarts holdoff
    connection_flag = 1'b1;
    repeat (3) tick();
    connection_warning_flag = 1'b1;
    tick();
    check("restart_stay", state, 1);
    connection_warning_flag = 1'b0;
    repeat (3) tick();
    check("restart_hold", state, 1);
    tick();
    check("restart_linked", state, 2);
    // DISCONNECTED ignores connection while warned
    connection_flag = 1'b0;
    tick();
    exp_drop++;
    connection_flag = 1'b1;
    connection_warning_flag = 1'b1;
    tick();
    check("disc_warn_stay", state, 0);
    check("disc_drops", drop_count, exp_drop);
    // saturation
    for (int i = 0; i < 252; i++) begin
      go_linked();
      connection_flag = 1'b0;
      tick();
      exp_drop = (exp_drop < 255) ? exp_drop + 1 : 255;
    end
    check("sat_drops", drop_count, exp_drop);
    check("sat_drops_255", drop_count, 255);
    // reset in WARNING
    go_linked();
    connection_warning_flag = 1'b1;
    tick();
    check("pre_rst_state", state, 3);
    tx_request = 1'b1;
    #2;
    resetn = 1'b0;
    #1;
    check("arst_state", state, 0);
    check("arst_link_up", link_up, 0);
    check("arst_flush", flush_pulse, 0);
    check("arst_led", status_led, 0);
    check("arst_drops", drop_count, 0);
    check("arst_grant", tx_grant, 0);
    tick();
    check("arst_flush_hold", flush_pulse, 0);
    connection_warning_flag = 1'b0;
    resetn = 1'b1;
    tick();
    check("post_rst_state", state, 1);
    check("post_rst_drops", drop_count, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
